// File: rtl/fence_pkg.sv
// rtl/fence_pkg.sv - shared types and constants for the fencing game logic
//
// Purpose: health controller FSM states, winner encodings, health width and a
// saturating health decrement helper.
// Ports: none (package).

package fence_pkg;

  localparam int HEALTH_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    COOLDOWN = 2'd2,
    OVER     = 2'd3
  } hc_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Health never wraps: a touch at 0 leaves it at 0.
  function automatic logic [HEALTH_W-1:0] sat_dec(input logic [HEALTH_W-1:0] h);
    return (h == '0) ? h : h - HEALTH_W'(1);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - loadable frame-driven down-counter with done flag
//
// Purpose: counts down by one on each tick, stops at zero, can be (re)loaded.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (count -> 0)
//   load_i      load load_val_i this cycle (wins over tick_i)
//   load_val_i  value to load
//   tick_i      decrement (typically new_frame)
//   done_o      count currently equals DONE_VAL

module frame_countdown #(
  parameter int WIDTH    = 6,
  parameter int DONE_VAL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == WIDTH'(DONE_VAL));

endmodule

// File: rtl/health_controller.sv
// rtl/health_controller.sv - fencer health, hit arbitration, cooldown and blink
//
// Purpose: owns both players' health, applies touches, enforces a frame-counted
// post-hit invulnerability window with blinking, and reports round-over/winner.
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   new_frame_in            one pulse per video frame
//   round_start_in          start/restart a round (wins over coincident hits)
//   hit_p1_in, hit_p2_in    touch pulses
//   health_p1_out/_p2_out   health 0..MAX_HEALTH
//   blink_p1_out/_p2_out    1 = hide that player this frame
//   round_over_out          high in OVER
//   winner_out              WIN_NONE / WIN_P1 / WIN_P2 / WIN_DRAW

module health_controller
  import fence_pkg::*;
#(
  parameter int MAX_HEALTH      = 5,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                new_frame_in,
  input  logic                round_start_in,
  input  logic                hit_p1_in,
  input  logic                hit_p2_in,
  output logic [HEALTH_W-1:0] health_p1_out,
  output logic [HEALTH_W-1:0] health_p2_out,
  output logic                blink_p1_out,
  output logic                blink_p2_out,
  output logic                round_over_out,
  output logic [1:0]          winner_out
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  // Blink divider holds frames remaining in the current half-period minus one.
  localparam logic [BL_W-1:0]     BL_LOAD = BL_W'(BLINK_FRAMES - 1);
  localparam logic [HEALTH_W-1:0] H_MAX   = HEALTH_W'(MAX_HEALTH);

  if (MAX_HEALTH < 1 || MAX_HEALTH > 7) begin : g_bad_max_health
    $error("health_controller: MAX_HEALTH must be 1..7");
  end
  if (COOLDOWN_FRAMES < 1) begin : g_bad_cooldown
    $error("health_controller: COOLDOWN_FRAMES must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("health_controller: BLINK_FRAMES must be >= 1");
  end

  hc_state_t           state_q, state_d;
  logic [HEALTH_W-1:0] h1_q, h1_d, h2_q, h2_d;
  logic [1:0]          blink_q, blink_d;   // bit0 = P1, bit1 = P2
  logic [1:0]          mask_q, mask_d;     // players hit at cooldown entry
  logic                over_q, over_d;
  logic [1:0]          win_q, win_d;

  logic                cd_load, cd_tick, cd_done;
  logic [CD_W-1:0]     cd_val;
  logic                bl_load, bl_tick, bl_done;
  logic [BL_W-1:0]     bl_val;

  logic                hit_any;
  logic [HEALTH_W-1:0] dec1, dec2;

  assign hit_any = hit_p1_in | hit_p2_in;
  assign dec1    = hit_p1_in ? sat_dec(h1_q) : h1_q;
  assign dec2    = hit_p2_in ? sat_dec(h2_q) : h2_q;

  frame_countdown #(.WIDTH(CD_W), .DONE_VAL(1)) u_cooldown (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (cd_load),
    .load_val_i (cd_val),
    .tick_i     (cd_tick),
    .done_o     (cd_done)
  );

  // Blink divider toggles when its count has run out, then reloads.
  frame_countdown #(.WIDTH(BL_W), .DONE_VAL(0)) u_blink (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (bl_load),
    .load_val_i (bl_val),
    .tick_i     (bl_tick),
    .done_o     (bl_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      h1_q    <= H_MAX;
      h2_q    <= H_MAX;
      blink_q <= '0;
      mask_q  <= '0;
      over_q  <= 1'b0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      blink_q <= blink_d;
      mask_q  <= mask_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (round_start_in) state_d = PLAY;
      PLAY: begin
        if (round_start_in) begin
          state_d = PLAY;
        end else if (hit_any) begin
          state_d = (dec1 == '0 || dec2 == '0) ? OVER : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (round_start_in || (new_frame_in && cd_done)) state_d = PLAY;
      end
      OVER:     if (round_start_in) state_d = PLAY;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    h1_d    = h1_q;
    h2_d    = h2_q;
    blink_d = blink_q;
    mask_d  = mask_q;
    over_d  = over_q;
    win_d   = win_q;
    cd_load = 1'b0;
    cd_val  = CD_LOAD;
    cd_tick = 1'b0;
    bl_load = 1'b0;
    bl_val  = BL_LOAD;
    bl_tick = 1'b0;

    if (round_start_in) begin
      h1_d    = H_MAX;
      h2_d    = H_MAX;
      blink_d = '0;
      mask_d  = '0;
      over_d  = 1'b0;
      win_d   = WIN_NONE;
      cd_load = 1'b1;
      cd_val  = '0;
      bl_load = 1'b1;
      bl_val  = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit_any) begin
            h1_d = dec1;
            h2_d = dec2;
            if (state_d == OVER) begin
              over_d = 1'b1;
              if (dec1 == '0 && dec2 == '0) win_d = WIN_DRAW;
              else if (dec2 == '0)          win_d = WIN_P1;
              else                          win_d = WIN_P2;
            end else begin
              mask_d  = {hit_p2_in, hit_p1_in};
              blink_d = {hit_p2_in, hit_p1_in};
              cd_load = 1'b1;
              bl_load = 1'b1;
            end
          end
        end
        COOLDOWN: begin
          // Hits are dropped here; only frames advance the window.
          if (new_frame_in) begin
            cd_tick = 1'b1;
            if (cd_done) begin
              blink_d = '0;
              mask_d  = '0;
            end else if (bl_done) begin
              blink_d = blink_q ^ mask_q;
              bl_load = 1'b1;
            end else begin
              bl_tick = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign health_p1_out  = h1_q;
  assign health_p2_out  = h2_q;
  assign blink_p1_out   = blink_q[0];
  assign blink_p2_out   = blink_q[1];
  assign round_over_out = over_q;
  assign winner_out     = win_q;

endmodule

// File: tb/tb_health_controller.sv
// tb/tb_health_controller.sv - directed self-checking bench for health_controller

module tb_health_controller;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       new_frame_in = 1'b0;
  logic       round_start_in = 1'b0;
  logic       hit_p1_in = 1'b0;
  logic       hit_p2_in = 1'b0;
  logic [2:0] health_p1_out;
  logic [2:0] health_p2_out;
  logic       blink_p1_out;
  logic       blink_p2_out;
  logic       round_over_out;
  logic [1:0] winner_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  health_controller #(
    .MAX_HEALTH      (5),
    .COOLDOWN_FRAMES (60),
    .BLINK_FRAMES    (8)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_frame_in   (new_frame_in),
    .round_start_in (round_start_in),
    .hit_p1_in      (hit_p1_in),
    .hit_p2_in      (hit_p2_in),
    .health_p1_out  (health_p1_out),
    .health_p2_out  (health_p2_out),
    .blink_p1_out   (blink_p1_out),
    .blink_p2_out   (blink_p2_out),
    .round_over_out (round_over_out),
    .winner_out     (winner_out)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       rs;
    logic       fr;
    logic       h1;
    logic       h2;
    logic [2:0] e_h1;
    logic [2:0] e_h2;
    logic       e_b1;
    logic       e_b2;
    logic       e_over;
    logic [1:0] e_win;
  } vec_t;

  vec_t tbl[13];

  // Inputs are applied for exactly one rising edge; outputs are sampled 1 time
  // unit after that edge.
  task automatic drive(input logic r, input logic rs, input logic fr,
                       input logic h1, input logic h2);
    @(negedge clk_in);
    rst_in = r;
    round_start_in = rs;
    new_frame_in = fr;
    hit_p1_in = h1;
    hit_p2_in = h2;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    round_start_in = 1'b0;
    new_frame_in = 1'b0;
    hit_p1_in = 1'b0;
    hit_p2_in = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [2:0] e1, input logic [2:0] e2,
                       input logic eb1, input logic eb2, input logic eo,
                       input logic [1:0] ew);
    logic [10:0] act;
    logic [10:0] exp;
    act = {health_p1_out, health_p2_out, blink_p1_out, blink_p2_out, round_over_out, winner_out};
    exp = {e1, e2, eb1, eb2, eo, ew};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got h1=%0d h2=%0d b1=%0b b2=%0b over=%0b win=%b, want h1=%0d h2=%0d b1=%0b b2=%0b over=%0b win=%b",
               name, health_p1_out, health_p2_out, blink_p1_out, blink_p2_out,
               round_over_out, winner_out, e1, e2, eb1, eb2, eo, ew);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic rs,
                              input logic fr, input logic h1, input logic h2,
                              input logic [2:0] e1, input logic [2:0] e2,
                              input logic eb1, input logic eb2, input logic eo,
                              input logic [1:0] ew);
    vec_t v;
    v.name = n; v.rst = r; v.rs = rs; v.fr = fr; v.h1 = h1; v.h2 = h2;
    v.e_h1 = e1; v.e_h2 = e2; v.e_b1 = eb1; v.e_b2 = eb2; v.e_over = eo; v.e_win = ew;
    return v;
  endfunction

  initial begin
    //              name              rst rs fr h1 h2   h1 h2 b1 b2 ov win
    tbl[0]  = mk("reset",             1, 0, 0, 0, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[1]  = mk("idle_hit_ignored",  0, 0, 0, 1, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[2]  = mk("round_start",       0, 1, 0, 0, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[3]  = mk("play_quiet",        0, 0, 0, 0, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[4]  = mk("play_hit_p1",       0, 0, 0, 1, 0,   4, 5, 1, 0, 0, 2'b00);
    tbl[5]  = mk("cd_hit_p2_drop",    0, 0, 0, 0, 1,   4, 5, 1, 0, 0, 2'b00);
    tbl[6]  = mk("cd_frame_and_hit",  0, 0, 1, 0, 1,   4, 5, 1, 0, 0, 2'b00);
    tbl[7]  = mk("cd_restart_wins",   0, 1, 0, 1, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[8]  = mk("double_touch",      0, 0, 0, 1, 1,   4, 4, 1, 1, 0, 2'b00);
    tbl[9]  = mk("restart_again",     0, 1, 0, 0, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[10] = mk("play_hit_p2",       0, 0, 0, 0, 1,   5, 4, 0, 1, 0, 2'b00);
    tbl[11] = mk("reset_mid_cd",      1, 0, 1, 1, 0,   5, 5, 0, 0, 0, 2'b00);
    tbl[12] = mk("idle_after_reset",  0, 0, 0, 0, 1,   5, 5, 0, 0, 0, 2'b00);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].rs, tbl[i].fr, tbl[i].h1, tbl[i].h2);
      check(tbl[i].name, tbl[i].e_h1, tbl[i].e_h2, tbl[i].e_b1, tbl[i].e_b2,
            tbl[i].e_over, tbl[i].e_win);
    end

    // Full cooldown: dropped hits, blink phases every 8 frames, exit on frame 60.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("plan1_hit_p1", 3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 1; i <= 60; i++) begin
      logic eb;
      drive(1'b0, 1'b0, 1'b1, 1'b0, (i == 3 || i == 59));
      eb = (i == 60) ? 1'b0 : (((i / 8) % 2) == 0);
      check($sformatf("cd_frame_%0d", i), 3'd4, 3'd5, eb, 1'b0, 1'b0, 2'b00);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_cd_hit_p2", 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 2'b00);

    // Walk both down with double touches to a draw.
    for (int k = 3; k >= 1; k--) begin
      frames(60);
      check($sformatf("recover_%0d", k), 3'(k + 1), 3'(k + 1), 1'b0, 1'b0, 1'b0, 2'b00);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("double_%0d", k), 3'(k), 3'(k), 1'b1, 1'b1, 1'b0, 2'b00);
    end
    frames(60);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("draw", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b11);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("over_holds", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b11);

    // P1 wins after five touches on P2; extra touch must not wrap.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_from_over", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int k = 4; k >= 1; k--) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("p2_step_%0d", k), 3'd5, 3'(k), 1'b0, 1'b1, 1'b0, 2'b00);
      frames(60);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p1_wins", 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("no_wrap", 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_p1_win", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 2'b00);

    // P2 wins.
    for (int k = 4; k >= 1; k--) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("p1_step_%0d", k), 3'(k), 3'd5, 1'b1, 1'b0, 1'b0, 2'b00);
      frames(60);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("p2_wins", 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 2'b10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_from_over", 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
